// File: rtl/aespim_pkg.sv
// aespim_pkg: shared definitions for the aespim key-expansion controller
//   aes_op_e     accelerator op-codes used by the controller
//   kex_state_e  controller FSM states
//   AES_KEY_W / AES_WORD_W  cipher key and word widths
package aespim_pkg;

    localparam int AES_KEY_W  = 128;
    localparam int AES_WORD_W = 32;

    typedef enum logic [4:0] {
        OP_LD       = 5'b00000,
        OP_KEX_INIT = 5'b00010,
        OP_KEX_NEXT = 5'b00011
    } aes_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_STREAM,
        ST_DRAIN
    } kex_state_e;

endpackage

// File: rtl/aespim_kex_ctrl.sv
// aespim_kex_ctrl: sequences the aespim accelerator through an AES-128 key expansion
//   clk_i, rst_i                                   clock, synchronous active-high reset
//   key_valid_i, key_ready_o, key_i                cipher key request (ready only when idle)
//   rk_valid_o, rk_ready_i, rk_data_o,
//   rk_index_o, rk_last_o                          expanded word stream w4..w(4*NUM_ROUNDS+3)
//   busy_o                                         high whenever not idle
//   acc_start_o, acc_op_code_o, acc_data_o,
//   acc_data_i                                     accelerator command / result port
module aespim_kex_ctrl
    import aespim_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  key_valid_i,
    output logic                  key_ready_o,
    input  logic [AES_KEY_W-1:0]  key_i,
    output logic                  rk_valid_o,
    input  logic                  rk_ready_i,
    output logic [AES_WORD_W-1:0] rk_data_o,
    output logic [5:0]            rk_index_o,
    output logic                  rk_last_o,
    output logic                  busy_o,
    output logic                  acc_start_o,
    output logic [4:0]            acc_op_code_o,
    output logic [AES_WORD_W-1:0] acc_data_o,
    input  logic [AES_WORD_W-1:0] acc_data_i
);

    localparam logic [5:0] LAST_IDX = 6'(4 * NUM_ROUNDS + 3);

    kex_state_e            state_q;
    logic [AES_KEY_W-1:0]  key_q;
    logic [1:0]            cnt_q;
    logic                  rk_valid_q;
    logic [AES_WORD_W-1:0] rk_data_q;
    logic [5:0]            rk_index_q;
    logic                  rk_last_q;
    logic                  cap;
    logic                  fin;
    logic [5:0]            nidx;
    logic [1:0]            wsel;

    assign key_ready_o = state_q == ST_IDLE;
    assign busy_o      = !key_ready_o;
    assign rk_valid_o  = rk_valid_q;
    assign rk_data_o   = rk_data_q;
    assign rk_index_o  = rk_index_q;
    assign rk_last_o   = rk_last_q;

    // While streaming a request is always outstanding, so a free (or freeing)
    // output slot is all that is needed to take the accelerator's word.
    assign cap  = state_q == ST_STREAM && (!rk_valid_q || rk_ready_i);
    assign nidx = rk_index_q == 6'd0 ? 6'd4 : rk_index_q + 6'd1;
    assign fin  = nidx == LAST_IDX;

    // The accelerator is loaded w3 first, then w0, w1, w2.
    assign wsel = cnt_q - 2'd1;

    // The next-word request must share the capture edge, hence these
    // outputs follow rk_ready_i combinationally while streaming.
    assign acc_start_o   = state_q == ST_LOAD || state_q == ST_INIT || (cap && !fin);
    assign acc_op_code_o = state_q == ST_INIT ? OP_KEX_INIT :
                           (state_q == ST_STREAM && acc_start_o) ? OP_KEX_NEXT : OP_LD;
    assign acc_data_o    = state_q == ST_LOAD ? key_q[{~wsel, 5'b0} +: AES_WORD_W] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            cnt_q      <= '0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_index_q <= '0;
            rk_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (key_valid_i) begin
                    key_q   <= key_i;
                    cnt_q   <= '0;
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_q <= ST_INIT;
                end
                ST_INIT: state_q <= ST_STREAM;
                ST_STREAM: if (cap) begin
                    rk_valid_q <= 1'b1;
                    rk_data_q  <= acc_data_i;
                    rk_index_q <= nidx;
                    rk_last_q  <= fin;
                    if (fin) state_q <= ST_DRAIN;
                end
                ST_DRAIN: if (rk_ready_i) begin
                    rk_valid_q <= 1'b0;
                    rk_index_q <= '0;
                    rk_last_q  <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aespim_kex_ctrl.sv
// tb_aespim_kex_ctrl: scoreboard bench for aespim_kex_ctrl with a behavioural accelerator
module tb_aespim_kex_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid_i = 1'b0;
    logic         key_ready_o;
    logic [127:0] key_i = '0;
    logic         rk_valid_o;
    logic         rk_ready_i = 1'b1;
    logic [31:0]  rk_data_o;
    logic [5:0]   rk_index_o;
    logic         rk_last_o;
    logic         busy_o;
    logic         acc_start_o;
    logic [4:0]   acc_op_code_o;
    logic [31:0]  acc_data_o;
    logic [31:0]  acc_data_i = 32'hdeadbeef;

    aespim_kex_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk_i(clk), .rst_i(rst),
        .key_valid_i(key_valid_i), .key_ready_o(key_ready_o), .key_i(key_i),
        .rk_valid_o(rk_valid_o), .rk_ready_i(rk_ready_i), .rk_data_o(rk_data_o),
        .rk_index_o(rk_index_o), .rk_last_o(rk_last_o), .busy_o(busy_o),
        .acc_start_o(acc_start_o), .acc_op_code_o(acc_op_code_o),
        .acc_data_o(acc_data_o), .acc_data_i(acc_data_i)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] w;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    int          pass_cnt = 0;
    int          chk_cnt = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    bit          mon_en = 1'b0;
    bit          rnd_rdy = 1'b0;
    bit          b2b_exp = 1'b0;
    logic [31:0] got[64];

    // ---------------- AES-128 key schedule from first principles ----------------
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(logic [7:0] x);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);
        return v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(int r);
        logic [7:0] c = 8'h01;
        for (int i = 1; i < r; i++) c = gmul(c, 8'h02);
        return c;
    endfunction

    function automatic logic [31:0] kex_word(logic [31:0] back4, logic [31:0] prev, int i);
        logic [31:0] t = prev;
        if (i % 4 == 0) begin
            t = {prev[23:0], prev[31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon(i / 4), 24'h0};
        end
        return back4 ^ t;
    endfunction

    // ---------------- accelerator model ----------------
    logic [31:0] ld_sr[4];
    logic [31:0] aw[44];
    int          ai = 0;

    always @(posedge clk) begin
        if (acc_start_o) begin
            if (acc_op_code_o == 5'b00000) begin
                ld_sr[0] = ld_sr[1]; ld_sr[1] = ld_sr[2]; ld_sr[2] = ld_sr[3]; ld_sr[3] = acc_data_o;
            end else if (acc_op_code_o == 5'b00010) begin
                aw[0] = ld_sr[1]; aw[1] = ld_sr[2]; aw[2] = ld_sr[3]; aw[3] = ld_sr[0];
                ai = 4;
                aw[4] = kex_word(aw[0], aw[3], 4);
                acc_data_i <= aw[4];
            end else if (acc_op_code_o == 5'b00011) begin
                if (ai < 43) begin
                    ai++;
                    aw[ai] = kex_word(aw[ai - 4], aw[ai - 1], ai);
                    acc_data_i <= aw[ai];
                end else acc_data_i <= $urandom();
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [127:0] g, input logic [127:0] e);
        chk_cnt++;
        if (g === e) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, g, e);
    endtask

    task automatic to_fail(input string nm);
        chk_cnt++;
        $display("FAIL %s: timed out waiting for the DUT", nm);
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, {key_ready_o, rk_valid_o, rk_data_o, rk_index_o, rk_last_o, busy_o,
                 acc_start_o, acc_op_code_o, acc_data_o},
            {1'b1, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0});
    endtask

    always @(posedge clk) begin
        cyc++;
        #1 rk_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    int           acc_cyc = 0, last_hs = -10, ld_seen = 0;
    bit           got_start, got_valid, got_last, timed, prev_stall;
    logic [31:0]  prev_data;
    logic [127:0] cur_key;
    logic [31:0]  w[44];
    exp_t         e;

    always @(negedge clk) begin
        if (rst || !mon_en) prev_stall = 1'b0;
        else begin
            chk("key_ready_idle", key_ready_o, sb.size() == 0);
            chk("busy", busy_o, !key_ready_o);
            if (!acc_start_o) chk("acc_quiet", {acc_op_code_o, acc_data_o}, 37'h0);
            if (acc_start_o && acc_op_code_o == 5'b00000) begin
                chk("ld_order", acc_data_o,
                    ld_seen == 0 ? cur_key[31:0] : cur_key[32 * (4 - ld_seen) +: 32]);
                ld_seen++;
            end
            if (acc_start_o && !got_start) begin
                got_start = 1'b1;
                chk("first_start_cyc", cyc, acc_cyc);
            end
            if (rk_valid_o && !got_valid) begin
                got_valid = 1'b1;
                chk("first_valid_cyc", cyc, acc_cyc + 6);
            end
            if (rk_last_o && !got_last) begin
                got_last = 1'b1;
                if (timed) chk("last_cyc", cyc, acc_cyc + 45);
            end
            if (rk_valid_o && !rk_ready_i) chk("stall_no_start", acc_start_o, 1'b0);
            if (prev_stall && rk_valid_o) chk("stall_hold", rk_data_o, prev_data);
            prev_stall = rk_valid_o && !rk_ready_i;
            prev_data = rk_data_o;
            if (rk_valid_o && rk_ready_i) begin
                if (sb.size() == 0) to_fail("unexpected_word");
                else begin
                    e = sb.pop_front();
                    chk("rk_word", {rk_index_o, rk_data_o, rk_last_o}, {e.idx, e.w, e.l});
                end
                got[rk_index_o] = rk_data_o;
                if (rk_last_o) last_hs = cyc;
            end
            if (key_valid_i && key_ready_o) begin
                cur_key = key_i;
                for (int i = 0; i < 4; i++) w[i] = key_i[32 * (3 - i) +: 32];
                for (int i = 4; i < 44; i++) begin
                    w[i] = kex_word(w[i - 4], w[i - 1], i);
                    sb.push_back('{idx: 6'(i), w: w[i], l: i == 43});
                end
                if (b2b_exp) begin
                    chk("b2b_accept_cyc", cyc, last_hs + 1);
                    b2b_exp = 1'b0;
                end
                acc_cyc = cyc + 1;
                ld_seen = 0;
                got_start = 1'b0; got_valid = 1'b0; got_last = 1'b0;
                timed = !rnd_rdy;
                acc_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_acc(input string nm, input int limit);
        int n = acc_cnt;
        for (int i = 0; i < limit && acc_cnt == n; i++) begin
            @(posedge clk); #1;
        end
        if (acc_cnt == n) to_fail(nm);
    endtask

    task automatic send_key(input logic [127:0] k);
        key_i = k;
        key_valid_i = 1'b1;
        wait_acc("accept", 50);
        key_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int limit);
        for (int i = 0; i < limit && !(sb.size() == 0 && key_ready_o); i++) begin
            @(posedge clk); #1;
        end
        if (!(sb.size() == 0 && key_ready_o)) to_fail(nm);
    endtask

    logic [31:0] fips_lo[4] = '{32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605};
    logic [31:0] fips_hi[4] = '{32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_reset("reset_values");
        rst = 1'b0;
        mon_en = 1'b1;

        // known-answer expansion with the consumer always ready
        foreach (got[i]) got[i] = '0;
        send_key(FIPS_KEY);
        wait_idle("fips_done", 200);
        for (int i = 0; i < 4; i++) begin
            chk("fips_w4_7", got[4 + i], fips_lo[i]);
            chk("fips_w40_43", got[40 + i], fips_hi[i]);
        end

        // random keys under random backpressure
        rnd_rdy = 1'b1;
        for (int n = 0; n < 3; n++) begin
            send_key({$urandom(), $urandom(), $urandom(), $urandom()});
            wait_idle("rand_done", 2000);
        end
        rnd_rdy = 1'b0;

        // key_valid held across an expansion: second key taken right after the last handshake
        key_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_valid_i = 1'b1;
        wait_acc("b2b_first", 50);
        key_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        b2b_exp = 1'b1;
        wait_acc("b2b_second", 300);
        key_valid_i = 1'b0;
        wait_idle("b2b_done", 300);

        // reset in the middle of streaming, then a clean expansion
        rnd_rdy = 1'b1;
        send_key({$urandom(), $urandom(), $urandom(), $urandom()});
        for (int i = 0; i < 500 && rk_index_o != 6'd20; i++) begin
            @(posedge clk); #1;
        end
        if (rk_index_o != 6'd20) to_fail("reach_idx20");
        rst = 1'b1;
        mon_en = 1'b0;
        @(posedge clk); #1;
        chk_reset("midstream_reset");
        rst = 1'b0;
        sb.delete();
        rnd_rdy = 1'b0;
        mon_en = 1'b1;
        foreach (got[i]) got[i] = '0;
        send_key(FIPS_KEY);
        wait_idle("post_reset_done", 200);
        chk("post_reset_w4", got[4], fips_lo[0]);
        chk("post_reset_w43", got[43], fips_hi[3]);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
